// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file.
//   rf_state_e : controller state (ST_CLEAR zeroes the array, ST_RUN is normal use)
//   DEF_*      : default parameter values used by reg_file_sb and its sub-module
package reg_file_pkg;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_READ      = 2;
  localparam int DEF_BYPASS        = 1;
  localparam int DEF_PROBE_REG     = 10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer tracking for the register file.
// One pending bit per register: set when an instruction claims the register
// as its destination, cleared when the register is written. Set wins when both
// hit the same index in one cycle (the new producer is still outstanding).
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset (clears all bits)
//   run_i               : updates and hazard outputs are enabled only while high
//   we_i, wa_i          : register write (clears pending[wa_i])
//   issue_valid_i/_rd_i : destination claim (sets pending[issue_rd_i])
//   ra_i                : read addresses, one per read port
//   hazard_o            : per read port, the addressed register is still pending
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_READ      = DEF_NUM_READ,
  parameter int BYPASS        = DEF_BYPASS
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   run_i,
  input  logic                                   we_i,
  input  logic [ADDRESS_WIDTH-1:0]               wa_i,
  input  logic                                   issue_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]               issue_rd_i,
  input  logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] ra_i,
  output logic [NUM_READ-1:0]                    hazard_o
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] pending_q, pending_d;
  logic             wr_hit;
  logic             set_hit;

  assign wr_hit  = run_i && we_i && (wa_i != '0);
  assign set_hit = run_i && issue_valid_i && (issue_rd_i != '0);

  // Clear is applied first so a same-index set overrides it.
  always_comb begin
    pending_d = pending_q;
    if (wr_hit)  pending_d[wa_i]       = 1'b0;
    if (set_hit) pending_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // A write landing this cycle resolves the hazard when it is forwarded.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      hazard_o[i] = 1'b0;
      if (run_i && (ra_i[i] != '0)) begin
        hazard_o[i] = pending_q[ra_i[i]] &&
                      !((BYPASS == 1) && wr_hit && (wa_i == ra_i[i]));
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with self-clearing start-up and a producer scoreboard.
// After reset the controller walks indices 1..DEPTH-1 writing zero (busy=1);
// then it accepts writes, combinational reads with optional same-cycle
// forwarding, and destination claims that raise per-port hazards.
// Register 0 is hard-wired to zero.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset (restarts clear)
//   we, wa, wd          : write port
//   ra / rd             : NUM_READ read ports (address in, data out)
//   issue_valid/issue_rd: destination claim for the scoreboard
//   hazard              : per read port, addressed register has a pending producer
//   busy                : clear sequence in progress
//   probe               : stored content of register PROBE_REG (never forwarded)
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_READ      = DEF_NUM_READ,
  parameter int BYPASS        = DEF_BYPASS,
  parameter int PROBE_REG     = DEF_PROBE_REG
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   we,
  input  logic [ADDRESS_WIDTH-1:0]               wa,
  input  logic [DATA_WIDTH-1:0]                  wd,
  input  logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] ra,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]    rd,
  input  logic                                   issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]               issue_rd,
  output logic [NUM_READ-1:0]                    hazard,
  output logic                                   busy,
  output logic [DATA_WIDTH-1:0]                  probe
);

  localparam int                       DEPTH     = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PROBE_IDX = ADDRESS_WIDTH'(PROBE_REG);

  rf_state_e                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic                     run;
  logic                     wr_en;

  // State register: reset restarts the clear walk at index 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= ADDRESS_WIDTH'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: leave CLEAR on the edge that zeroes the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDRESS_WIDTH'(1);
        if (cnt_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Outputs of the controller.
  always_comb begin
    busy  = (state_q == ST_CLEAR);
    run   = (state_q == ST_RUN);
    wr_en = run && we && (wa != '0);
  end

  // Array has no reset; it is zeroed only by the clear walk.
  always_ff @(posedge clk) begin
    if (busy)       mem_q[cnt_q] <= '0;
    else if (wr_en) mem_q[wa]    <= wd;
  end

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd[i] = '0;
      if (run && (ra[i] != '0)) begin
        if ((BYPASS == 1) && wr_en && (wa == ra[i])) rd[i] = wd;
        else                                          rd[i] = mem_q[ra[i]];
      end
    end
  end

  assign probe = (run && (PROBE_IDX != '0)) ? mem_q[PROBE_IDX] : '0;

  rf_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ),
    .BYPASS        (BYPASS)
  ) u_sb (
    .clk_i         (clk),
    .rst_i         (rst),
    .run_i         (run),
    .we_i          (we),
    .wa_i          (wa),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .ra_i          (ra),
    .hazard_o      (hazard)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one forwarding instance and one non-forwarding
// instance share all inputs. Expected values are queued as stimulus is driven
// and popped when the outputs are sampled mid-cycle.
module tb_reg_file_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int W  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    we = 1'b0;
  logic [AW-1:0]           wa = '0;
  logic [DW-1:0]           wd = '0;
  logic [NR-1:0][AW-1:0]   ra = '0;
  logic                    issue_valid = 1'b0;
  logic [AW-1:0]           issue_rd = '0;

  logic [NR-1:0][DW-1:0]   rd, rd_nb;
  logic [NR-1:0]           hazard, hazard_nb;
  logic                    busy, busy_nb;
  logic [DW-1:0]           probe, probe_nb;

  reg_file_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .hazard(hazard),
    .busy(busy), .probe(probe)
  );

  reg_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .hazard(hazard_nb),
    .busy(busy_nb), .probe(probe_nb)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic exp_push(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic obs_pop(input logic [W-1:0] obs);
    if (exp_q.size() == 0) begin
      check_val("sb_empty", W'(exp_q.size()), 1);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic iv, input logic [AW-1:0] ir,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(negedge clk);
    we = w; wa = a; wd = d; issue_valid = iv; issue_rd = ir;
    ra[0] = r0; ra[1] = r1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0; issue_valid = 1'b0; issue_rd = '0;
  endtask

  // Called at the negedge where rst was released; counts busy samples.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    idle_inputs();
    exp_push(tag, 31);
    obs_pop(W'(n));
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [32];
  logic          m_pend [32];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with write/issue noise that must be ignored
    repeat (2) @(negedge clk);
    we = 1'b1; wa = 5'd1; wd = 32'hFFFF_FFFF; issue_valid = 1'b1; issue_rd = 5'd3;
    ra[0] = 5'd1; ra[1] = 5'd3;
    #2;
    exp_push("rst_busy", 1);     obs_pop(W'(busy));
    exp_push("rst_rd0", 0);      obs_pop(rd[0]);
    exp_push("rst_hazard", 0);   obs_pop(W'(hazard));
    exp_push("rst_probe", 0);    obs_pop(probe);

    // clear timing (noise stays asserted through the whole walk)
    @(negedge clk);
    rst = 1'b0;
    wait_clear("clear_len");
    #2;
    exp_push("busy_after_clear", 0); obs_pop(W'(busy));

    // every index reads zero, no hazards (noise was ignored)
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, AW'(i), AW'(32 - i));
      #2;
      exp_push("clr_rd0", 0); obs_pop(rd[0]);
      exp_push("clr_rd1", 0); obs_pop(rd[1]);
      exp_push("clr_hz", 0);  obs_pop(W'(hazard));
    end

    // basic write/read, x0 stays zero even with forwarding
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 5, 0);
    #2;
    exp_push("wr_x5", 32'hDEAD_BEEF);    obs_pop(rd[0]);
    exp_push("wr_x5_nb", 32'hDEAD_BEEF); obs_pop(rd_nb[0]);
    drive(1, 0, 32'h1234, 0, 0, 0, 0);
    #2;
    exp_push("x0_fwd", 0); obs_pop(rd[1]);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    exp_push("x0_rd", 0);  obs_pop(rd[0]);

    // forwarding
    drive(1, 7, 32'h1111_1111, 0, 0, 0, 0);
    drive(1, 7, 32'hA5A5_A5A5, 0, 0, 0, 7);
    #2;
    exp_push("byp_rd1", 32'hA5A5_A5A5);   obs_pop(rd[1]);
    exp_push("nobyp_rd1", 32'h1111_1111); obs_pop(rd_nb[1]);
    drive(0, 0, 0, 0, 0, 0, 7);
    #2;
    exp_push("after_byp", 32'hA5A5_A5A5);    obs_pop(rd[1]);
    exp_push("after_byp_nb", 32'hA5A5_A5A5); obs_pop(rd_nb[1]);

    // scoreboard
    drive(0, 0, 0, 1, 3, 3, 3);
    #2;
    exp_push("hz_issue_cycle", 0); obs_pop(W'(hazard));
    drive(0, 0, 0, 0, 0, 3, 3);
    #2;
    exp_push("hz_pending", 3);     obs_pop(W'(hazard));
    exp_push("hz_pending_nb", 3);  obs_pop(W'(hazard_nb));
    drive(1, 3, 32'h33, 0, 0, 3, 3);
    #2;
    exp_push("hz_wr_cycle", 0);    obs_pop(W'(hazard));
    exp_push("hz_wr_cycle_nb", 3); obs_pop(W'(hazard_nb));
    drive(0, 0, 0, 0, 0, 3, 3);
    #2;
    exp_push("hz_after_wr", 0);    obs_pop(W'(hazard));
    exp_push("hz_after_wr_nb", 0); obs_pop(W'(hazard_nb));
    drive(0, 0, 0, 1, 3, 3, 3);
    drive(1, 3, 32'h44, 1, 3, 3, 3);
    #2;
    exp_push("hz_same_cycle", 0);  obs_pop(W'(hazard));
    drive(0, 0, 0, 1, 0, 3, 0);
    #2;
    exp_push("hz_set_wins", 3'h1); obs_pop(W'(hazard));
    exp_push("rd_x3", 32'h44);     obs_pop(rd[0]);
    drive(1, 3, 32'h44, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 3, 0);
    #2;
    exp_push("hz_x0_issue", 0);    obs_pop(W'(hazard));

    // probe and reset mid-operation
    drive(1, 10, 32'h55, 1, 4, 0, 0);
    #2;
    exp_push("probe_no_fwd", 0);   obs_pop(probe);
    drive(0, 0, 0, 0, 0, 4, 10);
    #2;
    exp_push("probe_val", 32'h55); obs_pop(probe);
    exp_push("hz_x4", 1);          obs_pop(W'(hazard));
    #1;
    rst = 1'b1;
    #1;
    exp_push("mid_rst_busy", 1);   obs_pop(W'(busy));
    exp_push("mid_rst_probe", 0);  obs_pop(probe);
    exp_push("mid_rst_hz", 0);     obs_pop(W'(hazard));
    exp_push("mid_rst_rd1", 0);    obs_pop(rd[1]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_clear("clear_len2");
    #2;
    exp_push("post_probe", 0);     obs_pop(probe);
    exp_push("post_hz", 0);        obs_pop(W'(hazard));
    exp_push("post_rd10", 0);      obs_pop(rd[1]);

    // randomized traffic against the model
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      logic          w, iv;
      logic [AW-1:0] a, ir;
      logic [DW-1:0] d;
      logic [AW-1:0] r [2];
      w  = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 11));
      d  = $urandom;
      iv = 1'($urandom_range(0, 1));
      ir = AW'($urandom_range(0, 11));
      r[0] = AW'($urandom_range(0, 11));
      r[1] = AW'($urandom_range(0, 11));
      drive(w, a, d, iv, ir, r[0], r[1]);
      for (int p = 0; p < 2; p++) begin
        logic hit;
        hit = w && (a == r[p]) && (r[p] != 0);
        exp_push("rnd_rd",    (r[p] == 0) ? '0 : (hit ? d : m_mem[r[p]]));
        exp_push("rnd_rd_nb", (r[p] == 0) ? '0 : m_mem[r[p]]);
        exp_push("rnd_hz",    W'((r[p] != 0) && m_pend[r[p]] && !hit));
        exp_push("rnd_hz_nb", W'((r[p] != 0) && m_pend[r[p]]));
      end
      exp_push("rnd_probe", m_mem[10]);
      #2;
      for (int p = 0; p < 2; p++) begin
        obs_pop(rd[p]);
        obs_pop(rd_nb[p]);
        obs_pop(W'(hazard[p]));
        obs_pop(W'(hazard_nb[p]));
      end
      obs_pop(probe);
      if (w && a != 0) begin
        m_mem[a]  = d;
        m_pend[a] = 1'b0;
      end
      if (iv && ir != 0) m_pend[ir] = 1'b1;
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register index width; depth = 2**ADDRESS_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NUM_READ, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, where 1 enables write-to-read forwarding in the same cycle.
REQ-005 SHALL have parameter PROBE_REG, default 10, the register index driven onto probe.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port we, input, 1, write enable.
REQ-009 SHALL have port wa, input, ADDRESS_WIDTH, write address.
REQ-010 SHALL have port wd, input, DATA_WIDTH, write data.
REQ-011 SHALL have port ra, input, NUM_READ x ADDRESS_WIDTH, read addresses.
REQ-012 SHALL have port rd, output, NUM_READ x DATA_WIDTH, read data.
REQ-013 SHALL have port issue_valid, input, 1, an instruction claiming a destination register.
REQ-014 SHALL have port issue_rd, input, ADDRESS_WIDTH, the claimed destination index.
REQ-015 SHALL have port hazard, output, NUM_READ, per read port: the addressed register has an outstanding producer.
REQ-016 SHALL have port busy, output, 1, high while the clear sequence runs.
REQ-017 SHALL have port probe, output, DATA_WIDTH, the current content of register PROBE_REG.

Function
REQ-018 SHALL hold register 0 at constant zero; writes to index 0 are discarded and reads of index 0 return 0.
REQ-019 SHALL implement a two-state FSM with states CLEAR and RUN.
REQ-020 SHALL, in CLEAR, write zero to register[cnt] each cycle, with cnt starting at 1 and incrementing by 1.
REQ-021 SHALL transition CLEAR->RUN on the edge that clears index 2**ADDRESS_WIDTH-1; the clear takes 2**ADDRESS_WIDTH-1 cycles (31 at default).
REQ-022 SHALL drive busy=1 exactly while the state is CLEAR.
REQ-023 SHALL, while busy, ignore we and issue_valid, and drive all rd, hazard and probe to 0.
REQ-024 SHALL, in RUN, write wd to register[wa] at the rising edge when we=1 and wa!=0.
REQ-025 SHALL make rd[i] combinational: 0 if ra[i]=0; otherwise wd if BYPASS=1, we=1 and wa=ra[i]; otherwise register[ra[i]].
REQ-026 SHALL keep a pending bit per register, all 0 after the clear.
REQ-027 SHALL set pending[issue_rd] at the edge when issue_valid=1 and issue_rd!=0.
REQ-028 SHALL clear pending[wa] at the edge when we=1 and wa!=0.
REQ-029 SHALL give set priority when both target the same index in one cycle, so the pending bit stays 1 (new producer).
REQ-030 SHALL drive hazard[i] = pending[ra[i]] AND NOT (BYPASS=1 AND we=1 AND wa=ra[i]); hazard[i] SHALL be 0 when ra[i]=0.
REQ-031 SHALL drive probe from stored register content only, with no bypass.
REQ-032 SHALL allow any number of read ports to address the same index with identical results.

Reset
REQ-033 SHALL, on rst assertion and asynchronously, force state=CLEAR, cnt=1, busy=1 and all pending=0.
REQ-034 SHALL restart the clear from cnt=1 when rst is asserted mid-clear or mid-RUN; array contents are zeroed only by the sequence, not by rst itself.

Structure
REQ-035 SHALL take the state enum (CLEAR, RUN) and default parameter constants from shared package reg_file_pkg.
REQ-036 SHALL place the pending-bit array and the hazard logic in sub-module rf_scoreboard.

Verification
REQ-037 SHALL verify clear timing: release rst and count cycles -> busy high for exactly 31 cycles, then rd=0 for every index 1..31.
REQ-038 SHALL verify basic write/read: write 0xDEADBEEF to x5, next cycle ra[0]=5 -> rd[0]=0xDEADBEEF; write 0x1234 to x0 -> rd reads 0.
REQ-039 SHALL verify bypass: in one cycle we=1, wa=7, wd=0xA5A5A5A5, ra[1]=7 -> rd[1]=0xA5A5A5A5 in the same cycle (BYPASS=1); with BYPASS=0 -> old value.
REQ-040 SHALL verify scoreboard: issue x3, ra[0]=3 -> hazard[0]=1; write x3 -> hazard[0]=0 in the write cycle and after; issue and write x3 in the same cycle -> pending stays 1.
REQ-041 SHALL verify probe and reset mid-operation: write 0x55 to x10 -> probe=0x55; assert rst -> busy=1 and probe=0 immediately; after 31 cycles probe=0 and pending all 0.
